// File: rtl/link_pkg.sv
// Shared types and constants for the DS link transmit scheduler.
// Optional statistics counters in the top level are enabled with the
// LINK_TX_SCHED_STATS_EN macro.

package link_pkg;

   // Character kinds offered to the DS encoder, in their wire encoding
   typedef enum logic [1:0] {
      CHR_DATA = 2'b00,
      CHR_FCT  = 2'b01,
      CHR_EOP  = 2'b10,
      CHR_NULL = 2'b11
   } chr_type_t;

   // Link start-up and run states of the transmit scheduler
   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_SEND_NULL = 2'b01,
      ST_SEND_FCT  = 2'b10,
      ST_RUN       = 2'b11
   } sched_state_t;

   // Characters granted by one FCT, and the largest credit window
   localparam int C_CREDIT_PER_FCT = 8;
   localparam int C_MAX_CREDIT     = 56;

   // True for characters that come from the upstream FIFO and cost credit
   function automatic logic isUpstream(input chr_type_t t);
      return (t == CHR_DATA) || (t == CHR_EOP);
   endfunction

endpackage

// File: rtl/link_credit_cnt.sv
// Credit counter: steps up by G_STEP, down by one, and flags any update
// that would leave the range 0..G_MAX instead of writing it.

module link_credit_cnt #(
   parameter int G_CNT_W = 6,
   parameter int G_STEP  = 8,
   parameter int G_MAX   = 56
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_clear,
   input  logic               i_inc,
   input  logic               i_dec,
   output logic [G_CNT_W-1:0] o_count,
   output logic               o_err
);

   localparam logic [G_CNT_W:0] L_STEP = (G_CNT_W+1)'(G_STEP);
   localparam logic [G_CNT_W:0] L_MAX  = (G_CNT_W+1)'(G_MAX);

   logic [G_CNT_W-1:0] r_count;
   logic [G_CNT_W:0]   w_up;
   logic [G_CNT_W:0]   w_next;
   logic               w_overflow;
   logic               w_underflow;

   // Compute the candidate value one bit wider than the counter so that an
   // overflow is visible before anything is written; taking from an empty
   // counter is an error even if a step up arrives in the same cycle.
   always_comb begin
      w_up        = {1'b0, r_count} + (i_inc ? L_STEP : '0);
      w_next      = w_up - {{G_CNT_W{1'b0}}, i_dec};
      w_underflow = i_dec && (r_count == '0);
      w_overflow  = i_inc && (w_next > L_MAX);
   end

   assign o_err   = w_overflow || w_underflow;
   assign o_count = r_count;

   // Hold the count; an erroneous update is discarded, and the owner clears
   // the counter when the link drops.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_count <= '0;
      end else if (!o_err) begin
         r_count <= w_next[G_CNT_W-1:0];
      end
   end

endmodule

// File: rtl/link_tx_scheduler.sv
// Transmit-side scheduler for one IEEE1355 DS link: runs the NULL/FCT
// start-up, arbitrates each encoder slot between FCT, upstream data/EOP and
// NULL fill, and tracks credit in both directions.
// Define LINK_TX_SCHED_STATS_EN to add accepted-character statistics ports.

module link_tx_scheduler
   import link_pkg::*;
#(
   parameter int G_CREDIT_PER_FCT = C_CREDIT_PER_FCT,
   parameter int G_MAX_CREDIT     = C_MAX_CREDIT,
   parameter int G_CNT_W          = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_link_en,
   input  logic             i_got_null,
   input  logic             i_rx_fct,
   input  logic             i_rx_char,
   input  logic [G_CNT_W:0] i_rx_free,
   input  logic             i_tx_valid,
   input  logic [7:0]       i_tx_data,
   input  logic             i_tx_eop,
   output logic             o_tx_ready,
   output logic             o_chr_valid,
   output logic [1:0]       o_chr_type,
   output logic [7:0]       o_chr_data,
   input  logic             i_chr_ready,
   output logic             o_link_run,
   output logic             o_credit_err
`ifdef LINK_TX_SCHED_STATS_EN
   ,
   output logic [31:0]      o_stat_data_cnt,
   output logic [15:0]      o_stat_fct_cnt,
   output logic [31:0]      o_stat_null_cnt
`endif
);

   localparam logic [G_CNT_W:0] L_STEP = (G_CNT_W+1)'(G_CREDIT_PER_FCT);
   localparam logic [G_CNT_W:0] L_MAX  = (G_CNT_W+1)'(G_MAX_CREDIT);

   sched_state_t       r_state;
   sched_state_t       w_stateNext;
   logic               r_chrValid;
   chr_type_t          r_chrType;
   logic [7:0]         r_chrData;
   logic               r_creditErr;

   chr_type_t          w_selType;
   logic [7:0]         w_selData;
   logic               w_selUpstream;
   logic               w_load;
   logic               w_accept;
   logic               w_abort;
   logic               w_active;
   logic               w_counting;
   logic               w_pendFct;
   logic               w_pendUp;
   logic [G_CNT_W:0]   w_rxOutEff;
   logic [G_CNT_W:0]   w_rxOutPlus;
   logic               w_fctOk;
   logic               w_txAvail;

   logic [G_CNT_W-1:0] w_txCredit;
   logic [G_CNT_W-1:0] w_rxOutstanding;
   logic               w_txInc;
   logic               w_txDec;
   logic               w_rxInc;
   logic               w_rxDec;
   logic               w_txErr;
   logic               w_rxErr;
   logic               w_err;

   // Handshake, abort and credit bookkeeping. The single output entry may
   // already hold an FCT or an upstream character that is only counted once
   // the encoder takes it, so the load decision charges that entry up front;
   // otherwise a back-to-back load could promise one FCT too many or spend
   // one credit twice.
   always_comb begin
      w_load      = !r_chrValid || i_chr_ready;
      w_accept    = r_chrValid && i_chr_ready;
      w_err       = w_txErr || w_rxErr;
      w_abort     = !i_link_en || w_err;
      w_active    = (r_state != ST_IDLE) && !w_abort;
      w_counting  = (r_state == ST_SEND_FCT) || (r_state == ST_RUN);
      w_pendFct   = r_chrValid && (r_chrType == CHR_FCT);
      w_pendUp    = r_chrValid && isUpstream(r_chrType);
      w_rxOutEff  = {1'b0, w_rxOutstanding} + (w_pendFct ? L_STEP : '0);
      w_rxOutPlus = w_rxOutEff + L_STEP;
      w_fctOk     = (w_rxOutPlus <= L_MAX) && (i_rx_free >= w_rxOutPlus);
      w_txAvail   = {1'b0, w_txCredit} > (G_CNT_W+1)'(w_pendUp);
      w_txInc     = i_rx_fct && w_counting;
      w_txDec     = w_accept && isUpstream(r_chrType);
      w_rxInc     = w_accept && (r_chrType == CHR_FCT) && w_counting;
      w_rxDec     = i_rx_char && w_counting;
   end

   // Next state and the character that would be loaded this cycle. Start-up
   // sends exactly one FCT before RUN, so a pending FCT blocks another.
   always_comb begin
      w_stateNext   = r_state;
      w_selType     = CHR_NULL;
      w_selData     = 8'h00;
      w_selUpstream = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_link_en) w_stateNext = ST_SEND_NULL;
         end
         ST_SEND_NULL: begin
            if (i_got_null) w_stateNext = ST_SEND_FCT;
         end
         ST_SEND_FCT: begin
            if (w_fctOk && !w_pendFct) w_selType = CHR_FCT;
            if (w_accept && (r_chrType == CHR_FCT)) w_stateNext = ST_RUN;
         end
         ST_RUN: begin
            if (w_fctOk) begin
               w_selType = CHR_FCT;
            end else if (i_tx_valid && w_txAvail) begin
               w_selUpstream = 1'b1;
               if (i_tx_eop) begin
                  w_selType = CHR_EOP;
               end else begin
                  w_selType = CHR_DATA;
                  w_selData = i_tx_data;
               end
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
      if (w_abort) w_stateNext = ST_IDLE;
   end

   // State register, plus the registered one-cycle credit error pulse
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_creditErr <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_creditErr <= w_err;
      end
   end

   // Single-entry output register: reloads whenever it is empty or its
   // content is being taken, holds steady under backpressure, and is
   // emptied (dropping any half-finished handshake) when the link drops.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || w_abort || (r_state == ST_IDLE)) begin
         r_chrValid <= 1'b0;
         r_chrType  <= CHR_DATA;
         r_chrData  <= 8'h00;
      end else if (w_load) begin
         r_chrValid <= 1'b1;
         r_chrType  <= w_selType;
         r_chrData  <= w_selData;
      end
   end

   link_credit_cnt #(
      .G_CNT_W (G_CNT_W),
      .G_STEP  (G_CREDIT_PER_FCT),
      .G_MAX   (G_MAX_CREDIT)
   ) u_txCredit (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_abort),
      .i_inc   (w_txInc),
      .i_dec   (w_txDec),
      .o_count (w_txCredit),
      .o_err   (w_txErr)
   );

   link_credit_cnt #(
      .G_CNT_W (G_CNT_W),
      .G_STEP  (G_CREDIT_PER_FCT),
      .G_MAX   (G_MAX_CREDIT)
   ) u_rxOutstanding (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (w_abort),
      .i_inc   (w_rxInc),
      .i_dec   (w_rxDec),
      .o_count (w_rxOutstanding),
      .o_err   (w_rxErr)
   );

   assign o_tx_ready   = w_active && w_load && w_selUpstream;
   assign o_chr_valid  = r_chrValid;
   assign o_chr_type   = r_chrType;
   assign o_chr_data   = r_chrData;
   assign o_link_run   = (r_state == ST_RUN);
   assign o_credit_err = r_creditErr;

`ifdef LINK_TX_SCHED_STATS_EN
   logic [31:0] r_statData;
   logic [15:0] r_statFct;
   logic [31:0] r_statNull;

   // Count characters the encoder actually took; only a full reset clears
   // these, so they survive link restarts.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_statData <= '0;
         r_statFct  <= '0;
         r_statNull <= '0;
      end else if (w_accept) begin
         if (isUpstream(r_chrType))   r_statData <= r_statData + 32'd1;
         if (r_chrType == CHR_FCT)    r_statFct  <= r_statFct + 16'd1;
         if (r_chrType == CHR_NULL)   r_statNull <= r_statNull + 32'd1;
      end
   end

   assign o_stat_data_cnt = r_statData;
   assign o_stat_fct_cnt  = r_statFct;
   assign o_stat_null_cnt = r_statNull;
`endif

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed self-checking bench for link_tx_scheduler: start-up, credit
// gating, FCT window, simultaneous credit events, overflow, backpressure
// and mid-run disable.

module tb_link_tx_scheduler;

   logic       clk = 1'b0;
   logic       rstN;
   logic       linkEn;
   logic       gotNull;
   logic       rxFct;
   logic       rxChar;
   logic [6:0] rxFree;
   logic       txValid;
   logic [7:0] txData;
   logic       txEop;
   logic       txReady;
   logic       chrValid;
   logic [1:0] chrType;
   logic [7:0] chrData;
   logic       chrReady;
   logic       linkRun;
   logic       creditErr;

   int checkCount = 0;
   int failCount  = 0;

   localparam logic [1:0] T_DATA = 2'b00;
   localparam logic [1:0] T_FCT  = 2'b01;
   localparam logic [1:0] T_EOP  = 2'b10;
   localparam logic [1:0] T_NULL = 2'b11;

   link_tx_scheduler dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_link_en    (linkEn),
      .i_got_null   (gotNull),
      .i_rx_fct     (rxFct),
      .i_rx_char    (rxChar),
      .i_rx_free    (rxFree),
      .i_tx_valid   (txValid),
      .i_tx_data    (txData),
      .i_tx_eop     (txEop),
      .o_tx_ready   (txReady),
      .o_chr_valid  (chrValid),
      .o_chr_type   (chrType),
      .o_chr_data   (chrData),
      .i_chr_ready  (chrReady),
      .o_link_run   (linkRun),
      .o_credit_err (creditErr)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the upstream FIFO face and let combinational outputs settle
   task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                input logic eop);
      txValid = valid;
      txData  = data;
      txEop   = eop;
      #1;
   endtask

   // Advance one clock and sample just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // NULLs until got_null, then exactly one FCT, then RUN with 8 promised
   task automatic startUp(input string tag);
      int fctSeen;
      int cyc;
      fctSeen = 0;
      linkEn  = 1'b1;
      repeat (3) tick();
      checkOutput({tag, "_null_valid"}, 32'(chrValid), 1);
      checkOutput({tag, "_null_type"}, 32'(chrType), 32'(T_NULL));
      checkOutput({tag, "_null_data"}, 32'(chrData), 0);
      checkOutput({tag, "_null_run"}, 32'(linkRun), 0);
      gotNull = 1'b1;
      tick();
      gotNull = 1'b0;
      for (cyc = 0; cyc < 10 && !linkRun; cyc++) begin
         tick();
         if (!linkRun && chrValid && chrType == T_FCT) fctSeen++;
      end
      checkOutput({tag, "_run"}, 32'(linkRun), 1);
      checkOutput({tag, "_fct_count"}, 32'(fctSeen), 1);
      checkOutput({tag, "_rx_out"}, 32'(dut.w_rxOutstanding), 8);
      checkOutput({tag, "_tx_credit"}, 32'(dut.w_txCredit), 0);
   endtask

   // Offer one upstream entry, see it loaded, and let the encoder take it
   task automatic sendOne(input string tag, input logic [7:0] b,
                          input logic eop, input logic withFct);
      applyStimulus(1'b1, b, eop);
      checkOutput({tag, "_tx_ready"}, 32'(txReady), 1);
      tick();
      checkOutput({tag, "_type"}, 32'(chrType), eop ? 32'(T_EOP) : 32'(T_DATA));
      checkOutput({tag, "_data"}, 32'(chrData), eop ? 0 : 32'(b));
      applyStimulus(1'b0, 8'h00, 1'b0);
      rxFct = withFct;
      tick();
      rxFct = 1'b0;
      checkOutput({tag, "_after_type"}, 32'(chrType), 32'(T_NULL));
   endtask

   initial begin
      int fctSeen;
      int dataSeen;

      rstN     = 1'b0;
      linkEn   = 1'b0;
      gotNull  = 1'b0;
      rxFct    = 1'b0;
      rxChar   = 1'b0;
      rxFree   = 7'd64;
      txValid  = 1'b0;
      txData   = 8'h00;
      txEop    = 1'b0;
      chrReady = 1'b1;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_chr_valid", 32'(chrValid), 0);
      checkOutput("rst_chr_type", 32'(chrType), 0);
      checkOutput("rst_chr_data", 32'(chrData), 0);
      checkOutput("rst_tx_ready", 32'(txReady), 0);
      checkOutput("rst_link_run", 32'(linkRun), 0);
      checkOutput("rst_credit_err", 32'(creditErr), 0);
      rstN = 1'b1;
      tick();
      checkOutput("idle_chr_valid", 32'(chrValid), 0);

      // Start-up
      startUp("startup");

      // Full FCT window: six more FCTs reach 56 outstanding
      fctSeen = 0;
      repeat (15) begin
         tick();
         if (chrValid && chrType == T_FCT) fctSeen++;
      end
      checkOutput("window_fct_count", 32'(fctSeen), 6);
      checkOutput("window_rx_out", 32'(dut.w_rxOutstanding), 56);

      // Eight received characters free room for exactly one more FCT
      fctSeen = 0;
      rxChar  = 1'b1;
      repeat (8) begin
         tick();
         if (chrValid && chrType == T_FCT) fctSeen++;
      end
      rxChar = 1'b0;
      repeat (6) begin
         tick();
         if (chrValid && chrType == T_FCT) fctSeen++;
      end
      checkOutput("refill_fct_count", 32'(fctSeen), 1);
      checkOutput("refill_rx_out", 32'(dut.w_rxOutstanding), 56);
      checkOutput("refill_credit_err", 32'(creditErr), 0);

      // Credit gating: no credit means only NULLs
      applyStimulus(1'b1, 8'hE6, 1'b0);
      checkOutput("gate_tx_ready0", 32'(txReady), 0);
      repeat (4) begin
         tick();
         checkOutput("gate_null_type", 32'(chrType), 32'(T_NULL));
         checkOutput("gate_tx_ready", 32'(txReady), 0);
      end
      rxFct = 1'b1;
      #1;
      checkOutput("gate_fct_cycle_ready", 32'(txReady), 0);
      tick();
      rxFct = 1'b0;
      #1;
      checkOutput("gate_ready_e6", 32'(txReady), 1);
      tick();
      checkOutput("gate_type_e6", 32'(chrType), 32'(T_DATA));
      checkOutput("gate_data_e6", 32'(chrData), 32'h0E6);
      applyStimulus(1'b1, 8'h2E, 1'b0);
      checkOutput("gate_ready_2e", 32'(txReady), 1);
      tick();
      checkOutput("gate_type_2e", 32'(chrType), 32'(T_DATA));
      checkOutput("gate_data_2e", 32'(chrData), 32'h02E);
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("gate_after_type", 32'(chrType), 32'(T_NULL));
      checkOutput("gate_tx_credit", 32'(dut.w_txCredit), 6);

      // Simultaneous credit gain and spend
      sendOne("sim_a", 8'h11, 1'b0, 1'b0);
      checkOutput("sim_credit5", 32'(dut.w_txCredit), 5);
      sendOne("sim_b", 8'h22, 1'b0, 1'b1);
      checkOutput("sim_credit12", 32'(dut.w_txCredit), 12);

      // EOP costs credit and carries a zero data byte
      sendOne("eop", 8'hAB, 1'b1, 1'b0);
      checkOutput("eop_credit", 32'(dut.w_txCredit), 11);

      // Build credit to 50, then overflow it
      rxFct = 1'b1;
      repeat (5) tick();
      rxFct = 1'b0;
      checkOutput("fill_credit51", 32'(dut.w_txCredit), 51);
      sendOne("fill", 8'h5A, 1'b0, 1'b0);
      checkOutput("fill_credit50", 32'(dut.w_txCredit), 50);
      checkOutput("fill_no_err", 32'(creditErr), 0);
      rxFct = 1'b1;
      tick();
      rxFct = 1'b0;
      checkOutput("ovf_credit_err", 32'(creditErr), 1);
      checkOutput("ovf_link_run", 32'(linkRun), 0);
      checkOutput("ovf_chr_valid", 32'(chrValid), 0);
      checkOutput("ovf_tx_credit", 32'(dut.w_txCredit), 0);
      checkOutput("ovf_rx_out", 32'(dut.w_rxOutstanding), 0);
      tick();
      checkOutput("ovf_err_pulse_end", 32'(creditErr), 0);
      startUp("after_err");

      // Backpressure: pending DATA held stable, transferred once
      repeat (15) tick();
      rxFct = 1'b1;
      tick();
      rxFct = 1'b0;
      applyStimulus(1'b1, 8'h3E, 1'b0);
      checkOutput("bp_ready_3e", 32'(txReady), 1);
      tick();
      checkOutput("bp_type_3e", 32'(chrType), 32'(T_DATA));
      checkOutput("bp_data_3e", 32'(chrData), 32'h03E);
      chrReady = 1'b0;
      applyStimulus(1'b1, 8'h55, 1'b0);
      checkOutput("bp_hold_ready0", 32'(txReady), 0);
      repeat (10) begin
         tick();
         checkOutput("bp_hold_valid", 32'(chrValid), 1);
         checkOutput("bp_hold_type", 32'(chrType), 32'(T_DATA));
         checkOutput("bp_hold_data", 32'(chrData), 32'h03E);
         checkOutput("bp_hold_ready", 32'(txReady), 0);
      end
      chrReady = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      tick();
      checkOutput("bp_release_type", 32'(chrType), 32'(T_NULL));
      dataSeen = 0;
      repeat (5) begin
         tick();
         if (chrValid && chrType == T_DATA) dataSeen++;
      end
      checkOutput("bp_no_repeat", 32'(dataSeen), 0);
      checkOutput("bp_tx_credit", 32'(dut.w_txCredit), 7);

      // Mid-operation disable drops a stalled character
      applyStimulus(1'b1, 8'h77, 1'b0);
      tick();
      checkOutput("dis_loaded_valid", 32'(chrValid), 1);
      checkOutput("dis_loaded_data", 32'(chrData), 32'h077);
      applyStimulus(1'b0, 8'h00, 1'b0);
      chrReady = 1'b0;
      linkEn   = 1'b0;
      tick();
      checkOutput("dis_chr_valid", 32'(chrValid), 0);
      checkOutput("dis_link_run", 32'(linkRun), 0);
      checkOutput("dis_tx_credit", 32'(dut.w_txCredit), 0);
      checkOutput("dis_rx_out", 32'(dut.w_rxOutstanding), 0);
      checkOutput("dis_tx_ready", 32'(txReady), 0);
      chrReady = 1'b1;
      startUp("reenable");

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/link_tx_scheduler.md
Name: link_tx_scheduler

Overview:
- Sequences the transmit side of one IEEE1355 DS link inside the node.
- Each character slot offered to the DS encoder is granted to one of four sources: FCT token, data character, EOP marker or NULL fill.
- Tracks transmit credit earned from received FCTs, and receive credit promised to the far end against free space in the local RX FIFO.
- Runs the link start-up sequence: NULLs, then FCTs, then data.

Parameters:
- G_CREDIT_PER_FCT, 8: characters granted per FCT, in both directions.
- G_MAX_CREDIT, 56: maximum credit held or outstanding; must be a multiple of G_CREDIT_PER_FCT.
- G_CNT_W, 6: width of credit counters; must satisfy 2**G_CNT_W > G_MAX_CREDIT.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- link_en  in  1  link enable; low forces IDLE.
- got_null  in  1  pulse: decoder received its first NULL.
- rx_fct  in  1  pulse: decoder received an FCT.
- rx_char  in  1  pulse: decoder received a data or EOP character.
- rx_free  in  G_CNT_W+1  free entries in the local RX FIFO.
- tx_valid  in  1  upstream TX FIFO has a character.
- tx_data  in  8  upstream data byte.
- tx_eop  in  1  upstream entry is an EOP marker; tx_data is ignored when set.
- tx_ready  out  1  upstream entry consumed this cycle.
- chr_valid  out  1  character presented to the encoder.
- chr_type  out  2  00 DATA, 01 FCT, 10 EOP, 11 NULL.
- chr_data  out  8  data byte; zero unless chr_type = DATA.
- chr_ready  in  1  encoder accepts the character this cycle.
- link_run  out  1  state is RUN.
- credit_err  out  1  one-cycle pulse: credit overflow or underflow.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - tx_credit = 0, rx_outstanding = 0.
  - Output register empty.
- Output register (single entry):
  - Holds chr_valid, chr_type and chr_data.
  - Loads when empty, or when chr_valid && chr_ready in the same cycle. Zero-bubble back-to-back transfers.
  - While chr_valid && !chr_ready, the fields are held stable.
  - tx_ready = load && (selected source is DATA or EOP). Upstream sees latency 1 cycle from tx_ready to chr_valid.
- States:
  - IDLE: chr_valid = 0. If link_en, go to SEND_NULL.
  - SEND_NULL: every load is NULL. When got_null, go to SEND_FCT.
  - SEND_FCT: FCT is loaded when fct_ok; otherwise NULL is loaded. After the first FCT is accepted by the encoder, go to RUN.
  - RUN: per-load priority is:
    1. FCT, if fct_ok.
    2. Upstream entry, if tx_valid && tx_credit > 0.
    3. NULL.
  - Any state: !link_en or a credit error moves to IDLE on the next cycle. The output register is cleared and both counters are zeroed. A character mid-handshake is dropped; the encoder is disabled concurrently.
- fct_ok condition: (rx_outstanding + G_CREDIT_PER_FCT <= G_MAX_CREDIT) && (rx_free >= rx_outstanding + G_CREDIT_PER_FCT).
- Counter updates. All arithmetic is unsigned at G_CNT_W+1 bits; overflow is checked before the result is written.
  - tx_credit:
    - +G_CREDIT_PER_FCT on rx_fct.
    - -1 on each accepted DATA or EOP.
    - Both in the same cycle: net +7.
  - rx_outstanding:
    - +G_CREDIT_PER_FCT when an FCT is accepted.
    - -1 on rx_char.
    - Both in the same cycle: net +7.
  - Errors (credit_err pulses, then IDLE):
    - tx_credit would exceed G_MAX_CREDIT.
    - rx_char arrives with rx_outstanding = 0.
  - rx_fct and rx_char are ignored in IDLE and SEND_NULL.
- Data and EOP consume credit; FCT and NULL do not.
- link_run = (state == RUN).

Optional Feature:
- Macro: LINK_TX_SCHED_STATS_EN.
- When defined:
  - Adds outputs stat_data_cnt (32 bits), stat_fct_cnt (16 bits) and stat_null_cnt (32 bits).
  - Each counts characters of that type accepted by the encoder, wrapping at 2**width.
  - Cleared by rst_n only; not cleared by link_en.
  - EOP is counted in stat_data_cnt.
- When undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package link_pkg holds:
  - chr_type_t enum (DATA, FCT, EOP, NULL) and its encoding.
  - sched_state_t enum (IDLE, SEND_NULL, SEND_FCT, RUN).
  - Constants C_CREDIT_PER_FCT = 8 and C_MAX_CREDIT = 56.
- One sub-module, link_credit_cnt: a saturation-checked up-by-N/down-by-1 counter with an error flag, instantiated twice (tx_credit, rx_outstanding).

Test Plan:
- Start-up: link_en=1, chr_ready=1, rx_free=64 → NULLs only until got_null. Then exactly one FCT, then RUN. rx_outstanding = 8.
- Credit gating: RUN, tx_credit 0, tx_valid with bytes 0xE6, 0x2E → only NULLs. One rx_fct pulse → both bytes sent as DATA. tx_credit = 6.
- Full window: rx_free=64, no rx_char → seven FCTs are sent, then no more. rx_outstanding = 56. rx_char ×8 → one further FCT.
- Simultaneous events: rx_fct in the same cycle as an accepted DATA → tx_credit 5→12. With tx_credit = 50, another rx_fct → credit_err pulse, IDLE next cycle.
- Backpressure: chr_ready=0 for 10 cycles while DATA 0x3E is pending → chr_type and chr_data stable, tx_ready=0. On release, the byte is transferred exactly once.
- Mid-operation disable: link_en dropped during RUN with chr_valid=1 → chr_valid=0 next cycle. State IDLE, both counters 0. Re-enable repeats the start-up sequence.
